// File: rtl/iommu_axil_reg_bridge.sv
// AXI4-Lite slave to regbus bridge for the IOMMU register map.
// One-entry AW/W/AR buffers, round-robin read/write arbitration, one regbus access at a time.
module iommu_axil_reg_bridge #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int REG_SPACE_BYTES = 4096,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]     aw_addr_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [DATA_WIDTH-1:0]     w_data_i,
    input  logic [DATA_WIDTH/8-1:0]   w_strb_i,
    output logic                      b_valid_o,
    input  logic                      b_ready_i,
    output logic [1:0]                b_resp_o,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]     ar_addr_i,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    output logic [DATA_WIDTH-1:0]     r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      reg_valid_o,
    output logic                      reg_write_o,
    output logic [ADDR_WIDTH-1:0]     reg_addr_o,
    output logic [DATA_WIDTH-1:0]     reg_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   reg_wstrb_o,
    input  logic                      reg_ready_i,
    input  logic [DATA_WIDTH-1:0]     reg_rdata_i,
    input  logic                      reg_error_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST    = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH:0] SPACE_LIMIT = (ADDR_WIDTH + 1)'(REG_SPACE_BYTES);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRSP, S_RRSP} state_t;
    typedef enum logic {GRANT_WRITE, GRANT_READ} grant_t;

    state_t                  state_reg;
    grant_t                  last_grant_reg;
    logic                    aw_full_reg;
    logic [ADDR_WIDTH-1:0]   aw_addr_reg;
    logic                    w_full_reg;
    logic [DATA_WIDTH-1:0]   w_data_reg;
    logic [STRB_WIDTH-1:0]   w_strb_reg;
    logic                    ar_full_reg;
    logic [ADDR_WIDTH-1:0]   ar_addr_reg;
    logic [CNT_W-1:0]        wait_cnt_reg;
    logic                    reg_valid_reg;
    logic                    reg_write_reg;
    logic [ADDR_WIDTH-1:0]   reg_addr_reg;
    logic [DATA_WIDTH-1:0]   reg_wdata_reg;
    logic [STRB_WIDTH-1:0]   reg_wstrb_reg;
    logic                    b_valid_reg;
    logic [1:0]              b_resp_reg;
    logic                    r_valid_reg;
    logic [1:0]              r_resp_reg;
    logic [DATA_WIDTH-1:0]   r_data_reg;

    logic wr_cand;
    logic rd_cand;
    logic grant_read;
    logic aw_oor;
    logic ar_oor;
    logic timeout_hit;

    assign wr_cand     = aw_full_reg & w_full_reg;
    assign rd_cand     = ar_full_reg;
    // Contended grants alternate; an uncontended candidate always wins.
    assign grant_read  = rd_cand & (~wr_cand | (last_grant_reg == GRANT_WRITE));
    assign aw_oor      = {1'b0, aw_addr_reg} >= SPACE_LIMIT;
    assign ar_oor      = {1'b0, ar_addr_reg} >= SPACE_LIMIT;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_reg == CNT_LAST);

    // Readies are held low while reset is asserted, not just after it.
    assign aw_ready_o  = ~aw_full_reg & ~rst_i;
    assign w_ready_o   = ~w_full_reg & ~rst_i;
    assign ar_ready_o  = ~ar_full_reg & ~rst_i;

    assign b_valid_o   = b_valid_reg;
    assign b_resp_o    = b_resp_reg;
    assign r_valid_o   = r_valid_reg;
    assign r_resp_o    = r_resp_reg;
    assign r_data_o    = r_data_reg;
    assign reg_valid_o = reg_valid_reg;
    assign reg_write_o = reg_write_reg;
    assign reg_addr_o  = reg_addr_reg;
    assign reg_wdata_o = reg_wdata_reg;
    assign reg_wstrb_o = reg_wstrb_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= S_IDLE;
            last_grant_reg <= GRANT_WRITE;
            aw_full_reg    <= 1'b0;
            aw_addr_reg    <= '0;
            w_full_reg     <= 1'b0;
            w_data_reg     <= '0;
            w_strb_reg     <= '0;
            ar_full_reg    <= 1'b0;
            ar_addr_reg    <= '0;
            wait_cnt_reg   <= '0;
            reg_valid_reg  <= 1'b0;
            reg_write_reg  <= 1'b0;
            reg_addr_reg   <= '0;
            reg_wdata_reg  <= '0;
            reg_wstrb_reg  <= '0;
            b_valid_reg    <= 1'b0;
            b_resp_reg     <= RESP_OKAY;
            r_valid_reg    <= 1'b0;
            r_resp_reg     <= RESP_OKAY;
            r_data_reg     <= '0;
        end else begin
            if (aw_valid_i && !aw_full_reg) begin
                aw_full_reg <= 1'b1;
                aw_addr_reg <= aw_addr_i;
            end
            if (w_valid_i && !w_full_reg) begin
                w_full_reg <= 1'b1;
                w_data_reg <= w_data_i;
                w_strb_reg <= w_strb_i;
            end
            if (ar_valid_i && !ar_full_reg) begin
                ar_full_reg <= 1'b1;
                ar_addr_reg <= ar_addr_i;
            end

            case (state_reg)
                S_IDLE: begin
                    if (wr_cand || rd_cand) begin
                        last_grant_reg <= grant_read ? GRANT_READ : GRANT_WRITE;
                        if (grant_read) begin
                            if (ar_oor) begin
                                r_valid_reg <= 1'b1;
                                r_resp_reg  <= RESP_SLVERR;
                                r_data_reg  <= '0;
                                state_reg   <= S_RRSP;
                            end else begin
                                reg_valid_reg <= 1'b1;
                                reg_write_reg <= 1'b0;
                                reg_addr_reg  <= ar_addr_reg;
                                reg_wdata_reg <= '0;
                                reg_wstrb_reg <= '0;
                                wait_cnt_reg  <= '0;
                                state_reg     <= S_REQ;
                            end
                        end else begin
                            if (aw_oor) begin
                                b_valid_reg <= 1'b1;
                                b_resp_reg  <= RESP_SLVERR;
                                state_reg   <= S_WRSP;
                            end else begin
                                reg_valid_reg <= 1'b1;
                                reg_write_reg <= 1'b1;
                                reg_addr_reg  <= aw_addr_reg;
                                reg_wdata_reg <= w_data_reg;
                                reg_wstrb_reg <= w_strb_reg;
                                wait_cnt_reg  <= '0;
                                state_reg     <= S_REQ;
                            end
                        end
                    end
                end
                S_REQ: begin
                    if (reg_ready_i) begin
                        reg_valid_reg <= 1'b0;
                        if (reg_write_reg) begin
                            b_valid_reg <= 1'b1;
                            b_resp_reg  <= reg_error_i ? RESP_SLVERR : RESP_OKAY;
                            state_reg   <= S_WRSP;
                        end else begin
                            r_valid_reg <= 1'b1;
                            r_resp_reg  <= reg_error_i ? RESP_SLVERR : RESP_OKAY;
                            r_data_reg  <= reg_rdata_i;
                            state_reg   <= S_RRSP;
                        end
                    end else if (timeout_hit) begin
                        // Abandon the hung access; any late reg_ready_i lands outside REQ.
                        reg_valid_reg <= 1'b0;
                        if (reg_write_reg) begin
                            b_valid_reg <= 1'b1;
                            b_resp_reg  <= RESP_SLVERR;
                            state_reg   <= S_WRSP;
                        end else begin
                            r_valid_reg <= 1'b1;
                            r_resp_reg  <= RESP_SLVERR;
                            r_data_reg  <= '0;
                            state_reg   <= S_RRSP;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_WRSP: begin
                    if (b_ready_i) begin
                        b_valid_reg <= 1'b0;
                        aw_full_reg <= 1'b0;
                        w_full_reg  <= 1'b0;
                        state_reg   <= S_IDLE;
                    end
                end
                S_RRSP: begin
                    if (r_ready_i) begin
                        r_valid_reg <= 1'b0;
                        ar_full_reg <= 1'b0;
                        state_reg   <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
